// File: rtl/buffer_pixeles_defs.sv
// Shared constants and helpers for the pixel unpacking buffer.
package buffer_pixeles_defs;

  localparam bit MsbFirst = 1'b1;
  localparam bit LsbFirst = 1'b0;

  // Ceiling log2; constant-evaluated for parameter derivation.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      res++;
    end
    return res;
  endfunction

  function automatic int unsigned idx_bits(input int unsigned pixels_per_word);
    return (clog2(pixels_per_word) > 1) ? clog2(pixels_per_word) : 1;
  endfunction

endpackage

// File: rtl/selector_pixel.sv
// Combinational pixel slice selector: picks pixel idx_i of a memory word in the chosen byte order.
module selector_pixel
  import buffer_pixeles_defs::*;
#(
  parameter int unsigned MEM_WORD_BITS = 32,
  parameter int unsigned PIXEL_BITS    = 8,
  parameter bit          MSB_FIRST     = MsbFirst,
  localparam int unsigned PixelsPerWord = MEM_WORD_BITS / PIXEL_BITS,
  localparam int unsigned IdxBits       = idx_bits(PixelsPerWord)
) (
  input  logic [MEM_WORD_BITS-1:0] word_i,
  input  logic [IdxBits-1:0]       idx_i,
  output logic [PIXEL_BITS-1:0]    pixel_o
);

  int unsigned slot;

  always_comb begin
    slot = (MSB_FIRST == MsbFirst) ? (PixelsPerWord - 1 - 32'(idx_i)) : 32'(idx_i);
    pixel_o = PIXEL_BITS'(word_i >> (slot * PIXEL_BITS));
  end

endmodule

// File: rtl/buffer_pixeles_fifo.sv
// Circular word store that unpacks memory words into a pixel stream with valid/ready on both sides.
module buffer_pixeles_fifo
  import buffer_pixeles_defs::*;
#(
  parameter int unsigned MEM_WORD_BITS = 32,
  parameter int unsigned PIXEL_BITS    = 8,
  parameter int unsigned WORDS_DEPTH   = 2,
  parameter bit          MSB_FIRST     = MsbFirst
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [MEM_WORD_BITS-1:0]      memory_data_i,
  input  logic                          mem_valid_i,
  output logic                          mem_ready_o,
  output logic [PIXEL_BITS-1:0]         pixel_o,
  output logic                          pixel_valid_o,
  input  logic                          pixel_ready_i,
  output logic [clog2(WORDS_DEPTH):0]   word_count_o
);

  localparam int unsigned PixelsPerWord = MEM_WORD_BITS / PIXEL_BITS;
  localparam int unsigned PtrBits       = clog2(WORDS_DEPTH);
  localparam int unsigned IdxBits       = idx_bits(PixelsPerWord);
  localparam logic [IdxBits-1:0] IdxLast   = IdxBits'(PixelsPerWord - 1);
  localparam logic [PtrBits:0]   CountFull = (PtrBits + 1)'(WORDS_DEPTH);

  logic [MEM_WORD_BITS-1:0] mem_q [WORDS_DEPTH];
  logic [PtrBits-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrBits-1:0]       rd_ptr_q, rd_ptr_d;
  logic [IdxBits-1:0]       idx_q, idx_d;
  logic [PtrBits:0]         count_q, count_d;
  logic                     push, pop, retire;
  logic [PIXEL_BITS-1:0]    sel_pixel;

  // Handshake outputs depend on registered state only.
  assign mem_ready_o   = (count_q != CountFull);
  assign pixel_valid_o = (count_q != '0);
  assign word_count_o  = count_q;

  assign push   = mem_valid_i && mem_ready_o;
  assign pop    = pixel_valid_o && pixel_ready_i;
  assign retire = pop && (idx_q == IdxLast);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      idx_d    = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (retire) begin
        idx_d    = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else if (pop) begin
        idx_d = idx_q + 1'b1;
      end
      unique case ({push, retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(WORDS_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= memory_data_i;
    end
  end

  selector_pixel #(
    .MEM_WORD_BITS (MEM_WORD_BITS),
    .PIXEL_BITS    (PIXEL_BITS),
    .MSB_FIRST     (MSB_FIRST)
  ) u_selector_pixel (
    .word_i  (mem_q[rd_ptr_q]),
    .idx_i   (idx_q),
    .pixel_o (sel_pixel)
  );

  assign pixel_o = pixel_valid_o ? sel_pixel : '0;

endmodule

// File: tb/tb_buffer_pixeles_fifo.sv
// Randomised and directed bench for buffer_pixeles_fifo, checked against a queue-based word/pixel model.
module tb_buffer_pixeles_fifo;

  localparam int unsigned WordBits = 32;
  localparam int unsigned PixBits  = 8;
  localparam int unsigned Depth    = 2;
  localparam int unsigned Ppw      = WordBits / PixBits;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic [WordBits-1:0] memory_data;
  logic                mem_valid;
  logic                pixel_ready;

  logic                mem_ready_m, pixel_valid_m, mem_ready_l, pixel_valid_l;
  logic [PixBits-1:0]  pixel_m, pixel_l;
  logic [1:0]          count_m, count_l;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO of whole words plus the number of pixels already taken from the head.
  logic [WordBits-1:0] wq[$];
  int unsigned         taken;

  always #5 clk = ~clk;

  buffer_pixeles_fifo #(
    .MEM_WORD_BITS (WordBits),
    .PIXEL_BITS    (PixBits),
    .WORDS_DEPTH   (Depth),
    .MSB_FIRST     (1'b1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .memory_data_i (memory_data),
    .mem_valid_i   (mem_valid),
    .mem_ready_o   (mem_ready_m),
    .pixel_o       (pixel_m),
    .pixel_valid_o (pixel_valid_m),
    .pixel_ready_i (pixel_ready),
    .word_count_o  (count_m)
  );

  buffer_pixeles_fifo #(
    .MEM_WORD_BITS (WordBits),
    .PIXEL_BITS    (PixBits),
    .WORDS_DEPTH   (Depth),
    .MSB_FIRST     (1'b0)
  ) dut_lsb (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .memory_data_i (memory_data),
    .mem_valid_i   (mem_valid),
    .mem_ready_o   (mem_ready_l),
    .pixel_o       (pixel_l),
    .pixel_valid_o (pixel_valid_l),
    .pixel_ready_i (pixel_ready),
    .word_count_o  (count_l)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [PixBits-1:0] exp_pixel(input bit msb);
    int unsigned slot;
    if (wq.size() == 0) return '0;
    slot = msb ? (Ppw - 1 - taken) : taken;
    return PixBits'(wq[0] >> (slot * PixBits));
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, "_count"}, 32'(count_m), wq.size());
    check_val({tag, "_valid"}, 32'(pixel_valid_m), 32'(wq.size() != 0));
    check_val({tag, "_ready"}, 32'(mem_ready_m), 32'(wq.size() < Depth));
    check_val({tag, "_pix_msb"}, 32'(pixel_m), 32'(exp_pixel(1'b1)));
    check_val({tag, "_pix_lsb"}, 32'(pixel_l), 32'(exp_pixel(1'b0)));
    check_val({tag, "_count_lsb"}, 32'(count_l), wq.size());
  endtask

  // One clock: drive inputs, check outputs before the edge, then advance the model at the edge.
  task automatic cycle(input logic mv, input logic [WordBits-1:0] d, input logic pr,
                       input logic fl, input string tag, output bit acc, output bit popped);
    bit do_pop;
    mem_valid   = mv;
    memory_data = d;
    pixel_ready = pr;
    flush       = fl;
    #2;
    check_outputs(tag);
    acc    = !fl && mv && (wq.size() < Depth);
    do_pop = !fl && pr && (wq.size() != 0);
    popped = do_pop;
    @(posedge clk);
    if (fl) begin
      wq.delete();
      taken = 0;
    end else begin
      if (do_pop) begin
        taken++;
        if (taken == Ppw) begin
          void'(wq.pop_front());
          taken = 0;
        end
      end
      if (acc) wq.push_back(d);
    end
    #1;
  endtask

  initial begin
    bit acc, popped;
    logic [WordBits-1:0] cur;
    int cyc, pops, last_pop;
    bit accepted_third;

    taken       = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    mem_valid   = 1'b0;
    memory_data = '0;
    pixel_ready = 1'b0;
    #12;
    check_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, consumer always ready.
    cycle(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, "single_push", acc, popped);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, "single_drain", acc, popped);

    // Fill to full with consumer stalled, then offer a third word.
    cycle(1'b1, 32'h11223344, 1'b0, 1'b0, "fill0", acc, popped);
    cycle(1'b1, 32'h55667788, 1'b0, 1'b0, "fill1", acc, popped);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h99AABBCC, 1'b0, 1'b0, "full_stall", acc, popped);
      check_val("full_reject", 32'(acc), 32'd0);
    end
    accepted_third = 1'b0;
    for (int i = 0; i < 20 && !accepted_third; i++) begin
      cycle(1'b1, 32'h99AABBCC, 1'b1, 1'b0, "full_release", acc, popped);
      accepted_third = acc;
    end
    check_val("third_accepted", 32'(accepted_third), 32'd1);
    for (int i = 0; i < 14; i++) cycle(1'b0, '0, 1'b1, 1'b0, "full_drain", acc, popped);

    // Flush mid-word with competing push and pop.
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, "flush_push", acc, popped);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, "flush_pop", acc, popped);
    cycle(1'b1, 32'hCAFEF00D, 1'b1, 1'b1, "flush_edge", acc, popped);
    cycle(1'b0, '0, 1'b0, 1'b0, "after_flush", acc, popped);
    check_val("flush_empty", 32'(count_m), 32'd0);

    // Continuous streaming of 16 words.
    cyc = 0; pops = 0; last_pop = -1;
    cur = $urandom;
    for (int words = 0; (words < 16 || wq.size() != 0) && cyc < 200; cyc++) begin
      cycle(words < 16, cur, 1'b1, 1'b0, "stream", acc, popped);
      if (acc) begin
        words++;
        cur = $urandom;
      end
      if (popped) begin
        pops++;
        last_pop = cyc;
      end
    end
    check_val("stream_pops", 32'(pops), 32'd64);
    check_val("stream_no_gap", 32'(last_pop), 32'd64);

    // Random traffic with occasional flush.
    cur = $urandom;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), cur, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 24) == 0), "random", acc, popped);
      if (acc) cur = $urandom;
    end

    // Asynchronous reset between edges, mid-word.
    cycle(1'b1, 32'h0F1E2D3C, 1'b0, 1'b0, "arst_push", acc, popped);
    cycle(1'b0, '0, 1'b1, 1'b0, "arst_pop", acc, popped);
    mem_valid   = 1'b0;
    pixel_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    wq.delete();
    taken = 0;
    #1;
    check_outputs("arst_now");
    @(posedge clk);
    #2;
    check_outputs("arst_held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h4B5A6978, 1'b1, 1'b0, "arst_new", acc, popped);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, "arst_stream", acc, popped);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
